// File: rtl/handshake_const_sink_checker.sv
// Constant-token sink: checks every accepted token against EXPECTED and
// emits a dataless ctrl token after each BATCH accepted tokens.
module handshake_const_sink_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECTED   = DATA_WIDTH'(17'b11111011111111000),
    parameter int                    BATCH      = 4,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [CNT_WIDTH-1:0]  match_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  error
);

    localparam int          BW       = 16;
    localparam logic [BW-1:0] BATCH_M1 = BW'(BATCH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] batch_cnt;
    logic          accept;
    logic          hit;
    logic          last;

    assign accept = ins_valid & ins_ready;
    assign hit    = (ins == EXPECTED);
    assign last   = (batch_cnt == BATCH_M1);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= COLLECT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (accept && last) state_d = DONE;
            DONE:    if (done_ready)     state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // ins_ready is the only output not purely registered: reset gates it low.
    always_comb begin
        ins_ready  = rst && (state_q == COLLECT);
        done_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            batch_cnt      <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            error          <= 1'b0;
        end else if (accept) begin
            batch_cnt <= last ? '0 : batch_cnt + BW'(1);
            if (hit) begin
                if (match_count != CNT_MAX) match_count <= match_count + CNT_WIDTH'(1);
            end else begin
                if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_WIDTH'(1);
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_const_sink_checker.sv
// Directed bench: instance a (BATCH=4, 16-bit counters) and
// instance b (BATCH=1, 4-bit counters) for saturation and half-rate throughput.
module tb_handshake_const_sink_checker;

    localparam logic [31:0] EXP = 32'h0001_F7F8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_a, ins_b;
    logic        ins_valid_a, ins_valid_b;
    logic        ins_ready_a, ins_ready_b;
    logic        done_valid_a, done_valid_b;
    logic        done_ready_a, done_ready_b;
    logic [15:0] match_a, mismatch_a;
    logic [3:0]  match_b, mismatch_b;
    logic        error_a, error_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    handshake_const_sink_checker #(.DATA_WIDTH(32), .BATCH(4), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .ins(ins_a), .ins_valid(ins_valid_a), .ins_ready(ins_ready_a),
        .done_valid(done_valid_a), .done_ready(done_ready_a),
        .match_count(match_a), .mismatch_count(mismatch_a), .error(error_a));

    handshake_const_sink_checker #(.DATA_WIDTH(32), .BATCH(1), .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .ins(ins_b), .ins_valid(ins_valid_b), .ins_ready(ins_ready_b),
        .done_valid(done_valid_b), .done_ready(done_ready_b),
        .match_count(match_b), .mismatch_count(mismatch_b), .error(error_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        ins_a = EXP; ins_valid_a = 1'b1; done_ready_a = 1'b1;
        ins_b = EXP; ins_valid_b = 1'b0; done_ready_b = 1'b1;

        // Reset with ins_valid held high
        tick();
        chk("rst_ready",    32'(ins_ready_a),  0);
        chk("rst_done",     32'(done_valid_a), 0);
        chk("rst_match",    32'(match_a),      0);
        chk("rst_mismatch", 32'(mismatch_a),   0);
        chk("rst_error",    32'(error_a),      0);
        tick();
        chk("rst_hold_match", 32'(match_a), 0);
        rst = 1'b1; ins_valid_a = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ins_ready_a), 1);

        // Four back-to-back matching tokens
        ins_valid_a = 1'b1; ins_a = EXP;
        tick(); tick(); tick();
        chk("b1_mid_done",  32'(done_valid_a), 0);
        chk("b1_mid_ready", 32'(ins_ready_a),  1);
        tick();
        ins_valid_a = 1'b0;
        chk("b1_done",      32'(done_valid_a), 1);
        chk("b1_bubble",    32'(ins_ready_a),  0);
        chk("b1_match",     32'(match_a),      4);
        tick();
        chk("b1_done_pulse", 32'(done_valid_a), 0);
        chk("b1_ready_back", 32'(ins_ready_a),  1);
        chk("b1_mismatch",   32'(mismatch_a),   0);

        // Mixed batch: two matches, two mismatches
        ins_valid_a = 1'b1; ins_a = EXP;
        tick();
        chk("b2_err_clean", 32'(error_a), 0);
        ins_a = 32'h0000_0000;
        tick();
        chk("b2_err_set",   32'(error_a),    1);
        chk("b2_mm1",       32'(mismatch_a), 1);
        ins_a = EXP;
        tick();
        ins_a = 32'hFFFF_FFFF;
        tick();
        chk("b2_done",      32'(done_valid_a), 1);
        chk("b2_match",     32'(match_a),      6);
        chk("b2_mismatch",  32'(mismatch_a),   2);

        // Downstream stalls 10 cycles while upstream keeps offering data
        done_ready_a = 1'b0; ins_a = 32'h0000_1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_done",  32'(done_valid_a), 1);
            chk("stall_ready", 32'(ins_ready_a),  0);
        end
        chk("stall_match",    32'(match_a),    6);
        chk("stall_mismatch", 32'(mismatch_a), 2);
        done_ready_a = 1'b1; ins_a = EXP;
        tick();
        chk("stall_xfer_done",  32'(done_valid_a), 0);
        chk("stall_xfer_ready", 32'(ins_ready_a),  1);
        chk("stall_xfer_match", 32'(match_a),      6);
        tick(); tick(); tick(); tick();
        chk("b3_done",   32'(done_valid_a), 1);
        chk("b3_match",  32'(match_a),      10);
        chk("b3_sticky", 32'(error_a),      1);
        tick();
        chk("b3_xfer", 32'(done_valid_a), 0);

        // Reset after two tokens of a batch discards the partial batch
        tick(); tick();
        chk("part_match", 32'(match_a), 12);
        rst = 1'b0;
        tick();
        chk("mid_rst_match", 32'(match_a),     0);
        chk("mid_rst_error", 32'(error_a),     0);
        chk("mid_rst_ready", 32'(ins_ready_a), 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_done", 32'(done_valid_a), 0);
        end
        tick();
        chk("post_rst_done",  32'(done_valid_a), 1);
        chk("post_rst_match", 32'(match_a),      4);
        ins_valid_a = 1'b0;
        tick();

        // BATCH=1: one token per two cycles, 4-bit counter saturates at 15
        ins_valid_b = 1'b1; ins_b = EXP;
        tick();
        chk("b1x_done",  32'(done_valid_b), 1);
        chk("b1x_ready", 32'(ins_ready_b),  0);
        chk("b1x_match", 32'(match_b),      1);
        tick();
        chk("b1x_xfer",  32'(done_valid_b), 0);
        chk("b1x_match2", 32'(match_b),     1);
        for (int i = 0; i < 8; i++) tick();
        chk("b1x_rate", 32'(match_b), 5);
        for (int i = 0; i < 30; i++) tick();
        chk("sat_match", 32'(match_b),     15);
        chk("sat_ready", 32'(ins_ready_b), 1);
        ins_b = 32'h0000_0000;
        tick();
        chk("sat_hold",     32'(match_b),    15);
        chk("sat_mismatch", 32'(mismatch_b), 1);
        chk("sat_error",    32'(error_b),    1);
        ins_valid_b = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
